// File: rtl/wb_copy_engine_pkg.sv
// ---------------------------------------------------------------------------
// wb_copy_engine_pkg
//   Shared definitions for the Wishbone copy engine: top-level sequencer
//   state encodings, single-transfer handshake state encodings, the
//   byte-select constant and the word-address increment helper.
// ---------------------------------------------------------------------------
package wb_copy_engine_pkg;

    // Copy sequencer states
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RD    = 3'd1;
    localparam logic [2:0] ST_WR    = 3'd2;
    localparam logic [2:0] ST_FIN   = 3'd3;
    localparam logic [2:0] ST_ABORT = 3'd4;

    // Single-transfer handshake states
    localparam logic [1:0] XS_IDLE = 2'd0;  // no request outstanding
    localparam logic [1:0] XS_BUSY = 2'd1;  // stb high, waiting for a termination
    localparam logic [1:0] XS_GAP  = 2'd2;  // stb low for one cycle after a retry

    localparam logic [3:0]  SEL_ALL    = 4'hF;
    localparam logic [31:0] WORD_BYTES = 32'd4;

    // Word-aligned address step; 32-bit modulo so 0xFFFF_FFFC wraps to 0.
    function automatic logic [31:0] next_word_addr(input logic [31:0] addr);
        return addr + WORD_BYTES;
    endfunction

endpackage

// File: rtl/wb_single_xfer.sv
// ---------------------------------------------------------------------------
// wb_single_xfer
//   Owns one Wishbone single read or write handshake: raises stb, waits for
//   a termination, reissues on retry after a one-cycle stb gap, and aborts on
//   error, retry exhaustion or timeout.  cyc is owned by the caller.
//
// Ports
//   clk_i, rst_i       clock, synchronous active-low reset
//   i_start            one-cycle request; latches i_we/i_adr/i_dat (idle only)
//   i_we/i_adr/i_dat   transfer direction, byte address, write data
//   i_ack/i_err/i_rty  Wishbone terminations from the responder
//   o_stb/o_we         Wishbone strobe and write enable
//   o_adr/o_dat        Wishbone address and write data
//   o_ack              transfer completed this cycle (dat_i valid for reads)
//   o_fail             transfer aborted this cycle
// ---------------------------------------------------------------------------
module wb_single_xfer
    import wb_copy_engine_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int MAX_RETRIES    = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        i_start,
    input  logic        i_we,
    input  logic [31:0] i_adr,
    input  logic [31:0] i_dat,
    input  logic        i_ack,
    input  logic        i_err,
    input  logic        i_rty,
    output logic        o_stb,
    output logic        o_we,
    output logic [31:0] o_adr,
    output logic [31:0] o_dat,
    output logic        o_ack,
    output logic        o_fail
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

    logic [1:0]       r_state;
    logic [TMO_W-1:0] r_tmo;
    logic [RTY_W-1:0] r_retry;
    logic             r_we;
    logic [31:0]      r_adr;
    logic [31:0]      r_dat;

    logic w_live;
    logic w_err;
    logic w_ack;
    logic w_rty;
    logic w_idle_cycle;
    logic w_abort;

    // Terminations only count while stb is high; err beats ack beats rty.
    assign w_live       = (r_state == XS_BUSY);
    assign w_err        = w_live & i_err;
    assign w_ack        = w_live & i_ack & ~i_err;
    assign w_rty        = w_live & i_rty & ~i_ack & ~i_err;
    assign w_idle_cycle = w_live & ~i_err & ~i_ack & ~i_rty;

    // The retry that would exceed the budget aborts instead of reissuing;
    // the last unanswered cycle of the timeout window aborts as well.
    assign w_abort = w_err
                   | (w_rty & (r_retry == RTY_MAX))
                   | (w_idle_cycle & (r_tmo == TMO_LAST));

    assign o_stb  = w_live;
    assign o_we   = r_we;
    assign o_adr  = r_adr;
    assign o_dat  = r_dat;
    assign o_ack  = w_ack;
    assign o_fail = w_abort;

    // NOTE: every register here uses <= so all of them update from the same
    // pre-edge values; blocking assignments would create ordering races.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= XS_IDLE;
            r_tmo   <= '0;
            r_retry <= '0;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_dat   <= '0;
        end else begin
            case (r_state)
                XS_IDLE: begin
                    if (i_start) begin
                        r_state <= XS_BUSY;
                        r_tmo   <= '0;
                        r_retry <= '0;
                        r_we    <= i_we;
                        r_adr   <= i_adr;
                        r_dat   <= i_dat;
                    end
                end
                XS_BUSY: begin
                    if (w_abort || w_ack) begin
                        r_state <= XS_IDLE;
                    end else if (w_rty) begin
                        r_retry <= r_retry + RTY_W'(1);
                        r_state <= XS_GAP;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                XS_GAP: begin
                    // stb rises again next cycle; the timeout window restarts.
                    r_state <= XS_BUSY;
                    r_tmo   <= '0;
                end
                default: r_state <= XS_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/wb_copy_engine.sv
// ---------------------------------------------------------------------------
// wb_copy_engine
//   Wishbone classic initiator copying len_i 32-bit words from src_i to
//   dst_i, one single read followed by one single write per word, with cyc
//   held for the whole copy.  Reports completion (done_o) and abort
//   (done_o with fail_o) on bus error, retry exhaustion or timeout.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-low reset
//   start_i               command strobe, accepted only while busy_o==0
//   src_i, dst_i, len_i   source/destination byte addresses, word count
//   busy_o                command in progress
//   done_o, fail_o        one-cycle completion pulse, abort flag alongside
//   cyc_o, stb_o, we_o    Wishbone cycle, strobe, write enable
//   adr_o, sel_o, dat_o   Wishbone address, byte selects (all), write data
//   dat_i                 Wishbone read data
//   ack_i, err_i, rty_i   Wishbone terminations
// ---------------------------------------------------------------------------
module wb_copy_engine
    import wb_copy_engine_pkg::*;
#(
    parameter int LEN_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int MAX_RETRIES    = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [31:0]          src_i,
    input  logic [31:0]          dst_i,
    input  logic [LEN_WIDTH-1:0] len_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 fail_o,
    output logic                 cyc_o,
    output logic                 stb_o,
    output logic                 we_o,
    output logic [31:0]          adr_o,
    output logic [3:0]           sel_o,
    output logic [31:0]          dat_o,
    input  logic [31:0]          dat_i,
    input  logic                 ack_i,
    input  logic                 err_i,
    input  logic                 rty_i
);

    logic [2:0]           r_state;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_fail;
    logic                 r_cyc;
    logic                 r_xfer_start;
    logic [31:0]          r_cur_src;
    logic [31:0]          r_cur_dst;
    logic [LEN_WIDTH-1:0] r_remaining;
    logic [31:0]          r_hold;

    logic        w_xfer_ack;
    logic        w_xfer_fail;
    logic        w_xfer_we;
    logic [31:0] w_xfer_adr;

    // Direction and address follow the state the sequencer has just entered;
    // the handshake latches them on r_xfer_start.
    assign w_xfer_we  = (r_state == ST_WR);
    assign w_xfer_adr = w_xfer_we ? r_cur_dst : r_cur_src;

    wb_single_xfer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .MAX_RETRIES    (MAX_RETRIES)
    ) u_xfer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_start (r_xfer_start),
        .i_we    (w_xfer_we),
        .i_adr   (w_xfer_adr),
        .i_dat   (r_hold),
        .i_ack   (ack_i),
        .i_err   (err_i),
        .i_rty   (rty_i),
        .o_stb   (stb_o),
        .o_we    (we_o),
        .o_adr   (adr_o),
        .o_dat   (dat_o),
        .o_ack   (w_xfer_ack),
        .o_fail  (w_xfer_fail)
    );

    assign busy_o = r_busy;
    assign done_o = r_done;
    assign fail_o = r_fail;
    assign cyc_o  = r_cyc;
    assign sel_o  = SEL_ALL;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            // NOTE: reset is sampled on the clock edge only, so it sits inside
            // the clocked block and rst_i stays out of the sensitivity list.
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_fail       <= 1'b0;
            r_cyc        <= 1'b0;
            r_xfer_start <= 1'b0;
            r_cur_src    <= '0;
            r_cur_dst    <= '0;
            r_remaining  <= '0;
            r_hold       <= '0;
        end else begin
            // Pulses default low and are re-asserted only where needed.
            r_done       <= 1'b0;
            r_fail       <= 1'b0;
            r_xfer_start <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_busy      <= 1'b1;
                        r_cur_src   <= src_i;
                        r_cur_dst   <= dst_i;
                        r_remaining <= len_i;
                        if (len_i == '0) begin
                            r_state <= ST_FIN;
                        end else begin
                            r_state      <= ST_RD;
                            r_cyc        <= 1'b1;
                            r_xfer_start <= 1'b1;
                        end
                    end
                end
                ST_RD: begin
                    if (w_xfer_fail) begin
                        r_state <= ST_ABORT;
                        r_cyc   <= 1'b0;
                    end else if (w_xfer_ack) begin
                        r_hold       <= dat_i;
                        r_state      <= ST_WR;
                        r_xfer_start <= 1'b1;
                    end
                end
                ST_WR: begin
                    if (w_xfer_fail) begin
                        r_state <= ST_ABORT;
                        r_cyc   <= 1'b0;
                    end else if (w_xfer_ack) begin
                        r_cur_src   <= next_word_addr(r_cur_src);
                        r_cur_dst   <= next_word_addr(r_cur_dst);
                        r_remaining <= r_remaining - LEN_WIDTH'(1);
                        if (r_remaining == LEN_WIDTH'(1)) begin
                            r_state <= ST_FIN;
                            r_cyc   <= 1'b0;
                        end else begin
                            r_state      <= ST_RD;
                            r_xfer_start <= 1'b1;
                        end
                    end
                end
                ST_FIN: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                ST_ABORT: begin
                    r_done  <= 1'b1;
                    r_fail  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_cyc   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_copy_engine.sv
// ---------------------------------------------------------------------------
// tb_wb_copy_engine
//   Bench for wb_copy_engine: a Wishbone responder with a preloaded source
//   memory, a queue of expected writes and completions, one task per scenario.
// ---------------------------------------------------------------------------
module tb_wb_copy_engine;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [31:0] src_i;
    logic [31:0] dst_i;
    logic [15:0] len_i;
    logic        busy_o, done_o, fail_o, cyc_o, stb_o, we_o;
    logic [31:0] adr_o, dat_o;
    logic [3:0]  sel_o;
    logic [31:0] dat_i;
    logic        ack_i, err_i, rty_i;

    always #5 clk_i = ~clk_i;

    wb_copy_engine #(
        .LEN_WIDTH      (16),
        .TIMEOUT_CYCLES (16),
        .MAX_RETRIES    (3)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .src_i   (src_i),
        .dst_i   (dst_i),
        .len_i   (len_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .fail_o  (fail_o),
        .cyc_o   (cyc_o),
        .stb_o   (stb_o),
        .we_o    (we_o),
        .adr_o   (adr_o),
        .sel_o   (sel_o),
        .dat_o   (dat_o),
        .dat_i   (dat_i),
        .ack_i   (ack_i),
        .err_i   (err_i),
        .rty_i   (rty_i)
    );

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
    } wr_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] src_mem [0:1023];
    wr_t         obs_q[$];
    int          obs_rd    = 0;
    wr_t         exp_q[$];
    bit          exp_done_q[$];
    int          ack_cnt   = 0;
    int          rty_given = 0;
    int          rty_limit = 0;
    logic [31:0] err_adr   = 32'h1;
    int          stb_rises = 0;
    logic        stb_prev  = 1'b0;

    // Low 4 KiB and the top 4 KiB (for wrap tests) are mapped; the rest is silent.
    function automatic bit mapped(input logic [31:0] a);
        return (a < 32'h1000) || (a >= 32'hFFFF_F000);
    endfunction

    // Responder: answers in the first cycle stb is seen high.
    initial begin
        ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0; dat_i = '0;
        forever begin
            @(posedge clk_i);
            #1;
            ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0; dat_i = '0;
            if (cyc_o && stb_o && mapped(adr_o)) begin
                if (adr_o == err_adr) begin
                    err_i = 1'b1;
                    ack_i = 1'b1;
                end else if (!we_o && rty_given < rty_limit) begin
                    rty_i = 1'b1;
                    rty_given++;
                end else if (!we_o) begin
                    ack_i = 1'b1;
                    dat_i = src_mem[adr_o[11:2]];
                    ack_cnt++;
                end else begin
                    ack_i = 1'b1;
                    obs_q.push_back(wr_t'{adr: adr_o, dat: dat_o});
                    ack_cnt++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_i);
            if (stb_o && !stb_prev) stb_rises++;
            stb_prev = stb_o;
        end
    end

    task automatic expect_copy(input logic [31:0] s, input logic [31:0] d, input int n);
        logic [31:0] sa, da;
        sa = s; da = d;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(wr_t'{adr: da, dat: src_mem[sa[11:2]]});
            sa = sa + 32'd4;
            da = da + 32'd4;
        end
    endtask

    task automatic start_cmd(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
        @(negedge clk_i);
        src_i = s; dst_i = d; len_i = n; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    // Waits for done_o, then pops the expected completion and expected writes.
    task automatic finish_cmd(input string name);
        bit  got, fl, want;
        wr_t e, o;
        got = 1'b0; fl = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done_o) begin got = 1'b1; fl = fail_o; break; end
            @(negedge clk_i);
        end
        n_checks++;
        if (got !== 1'b1) begin
            n_fail++;
            $display("FAIL %s done_timeout: done_o got 0 want 1 within 300 cycles", name);
        end else begin
            want = (exp_done_q.size() > 0) ? exp_done_q.pop_front() : 1'b0;
            n_checks++;
            if (fl !== want) begin
                n_fail++;
                $display("FAIL %s fail_o: got %0b want %0b", name, fl, want);
            end
            n_checks++;
            if (busy_o !== 1'b0 || cyc_o !== 1'b0 || stb_o !== 1'b0) begin
                n_fail++;
                $display("FAIL %s idle_at_done: busy/cyc/stb got %0b%0b%0b want 000",
                         name, busy_o, cyc_o, stb_o);
            end
            @(negedge clk_i);
            n_checks++;
            if (done_o !== 1'b0 || fail_o !== 1'b0) begin
                n_fail++;
                $display("FAIL %s pulse_width: done/fail got %0b%0b want 00", name, done_o, fail_o);
            end
        end
        while (obs_rd < obs_q.size()) begin
            o = obs_q[obs_rd];
            obs_rd++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL %s extra_write: got adr=%h dat=%h want none", name, o.adr, o.dat);
            end else begin
                e = exp_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL %s write: got adr=%h dat=%h want adr=%h dat=%h",
                             name, o.adr, o.dat, e.adr, e.dat);
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s missing_writes: got %0d outstanding want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic run_copy(input string name, input logic [31:0] s, input logic [31:0] d,
                            input logic [15:0] n, input int n_writes, input bit exp_fail);
        expect_copy(s, d, n_writes);
        exp_done_q.push_back(exp_fail);
        start_cmd(s, d, n);
        finish_cmd(name);
    endtask

    task automatic test_reset();
        rst_i = 1'b0; start_i = 1'b0; src_i = '0; dst_i = '0; len_i = '0;
        for (int i = 0; i < 1024; i++) src_mem[i] = 32'hC0DE_0000 + 32'(i);
        src_mem[64] = 32'd1; src_mem[65] = 32'd2; src_mem[66] = 32'd3;
        repeat (3) @(negedge clk_i);
        n_checks++;
        if ({busy_o, done_o, fail_o, cyc_o, stb_o, we_o} !== 6'b0 || adr_o !== '0 ||
            dat_o !== '0 || sel_o !== 4'hF) begin
            n_fail++;
            $display("FAIL reset_state: busy,done,fail,cyc,stb,we=%b adr=%h dat=%h sel=%h want 0/0/0/F",
                     {busy_o, done_o, fail_o, cyc_o, stb_o, we_o}, adr_o, dat_o, sel_o);
        end
        rst_i = 1'b1;
    endtask

    task automatic test_copy();
        int a0, r0;
        a0 = ack_cnt; r0 = stb_rises;
        expect_copy(32'h100, 32'h200, 3);
        exp_done_q.push_back(1'b0);
        start_cmd(32'h100, 32'h200, 16'd3);
        repeat (3) @(negedge clk_i);
        n_checks++;
        if (busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL copy_busy: busy_o got %0b want 1", busy_o);
        end
        // A second command while busy must be ignored.
        src_i = 32'h400; dst_i = 32'h480; len_i = 16'd5; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        finish_cmd("copy3");
        n_checks++;
        if (ack_cnt - a0 != 6) begin
            n_fail++;
            $display("FAIL copy_acks: got %0d want 6", ack_cnt - a0);
        end
        n_checks++;
        if (stb_rises - r0 != 6) begin
            n_fail++;
            $display("FAIL copy_stb_rises: got %0d want 6", stb_rises - r0);
        end
    endtask

    task automatic test_zero_len();
        bit saw_cyc;
        start_cmd(32'h100, 32'h300, 16'd0);
        saw_cyc = cyc_o;
        n_checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_len_c1: done/busy got %0b%0b want 01", done_o, busy_o);
        end
        @(negedge clk_i);
        saw_cyc = saw_cyc | cyc_o;
        n_checks++;
        if (done_o !== 1'b1 || fail_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_len_c2: done/fail/busy got %0b%0b%0b want 100", done_o, fail_o, busy_o);
        end
        @(negedge clk_i);
        saw_cyc = saw_cyc | cyc_o;
        n_checks++;
        if (done_o !== 1'b0 || saw_cyc !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_len_c3: done got %0b cyc seen %0b want 0 0", done_o, saw_cyc);
        end
    endtask

    task automatic test_retry_ok();
        int r0;
        r0 = stb_rises;
        rty_limit = rty_given + 2;
        run_copy("retry_ok", 32'h104, 32'h340, 16'd1, 1, 1'b0);
        n_checks++;
        if (stb_rises - r0 != 4) begin
            n_fail++;
            $display("FAIL retry_stb_rises: got %0d want 4", stb_rises - r0);
        end
    endtask

    task automatic test_retry_exhaust();
        int o0;
        o0 = obs_q.size();
        rty_limit = rty_given + 4;
        run_copy("retry_exhaust", 32'h108, 32'h380, 16'd2, 0, 1'b1);
        n_checks++;
        if (obs_q.size() != o0 || rty_given != rty_limit) begin
            n_fail++;
            $display("FAIL retry_exhaust_bus: writes got %0d want 0, rty given %0d want %0d",
                     obs_q.size() - o0, rty_given, rty_limit);
        end
    endtask

    task automatic test_timeout();
        int  k;
        bit  seen;
        start_cmd(32'h100, 32'h2000, 16'd1);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (stb_o && we_o) begin seen = 1'b1; break; end
            @(negedge clk_i);
        end
        k = 0;
        if (seen) begin
            for (int i = 0; i < 40; i++) begin
                @(negedge clk_i);
                k++;
                if (done_o) break;
            end
        end
        n_checks++;
        if (!seen || k != 17 || done_o !== 1'b1 || fail_o !== 1'b1 || cyc_o !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout: stb_seen=%0b cycles got %0d want 17, done/fail/cyc got %0b%0b%0b want 110",
                     seen, k, done_o, fail_o, cyc_o);
        end
        @(negedge clk_i);
        n_checks++;
        if (obs_q.size() != obs_rd) begin
            n_fail++;
            $display("FAIL timeout_writes: got %0d want 0", obs_q.size() - obs_rd);
            obs_rd = obs_q.size();
        end
    endtask

    task automatic test_err();
        // err raised together with ack on the second write: err must win.
        err_adr = 32'h604;
        run_copy("err_priority", 32'h110, 32'h600, 16'd3, 1, 1'b1);
        err_adr = 32'h1;
    endtask

    task automatic test_wrap();
        run_copy("wrap", 32'hFFFF_FFF8, 32'hFFFF_FFFC, 16'd3, 3, 1'b0);
    endtask

    task automatic test_reset_mid();
        bit seen;
        int dones;
        start_cmd(32'h100, 32'h900, 16'd3);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (stb_o && we_o && adr_o == 32'h904) begin seen = 1'b1; break; end
            @(negedge clk_i);
        end
        rst_i = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if (!seen || cyc_o !== 1'b0 || stb_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: second WR seen=%0b cyc/stb/busy got %0b%0b%0b want 000",
                     seen, cyc_o, stb_o, busy_o);
        end
        rst_i = 1'b1;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            if (done_o) dones++;
        end
        n_checks++;
        if (dones != 0) begin
            n_fail++;
            $display("FAIL reset_mid_done: got %0d pulses want 0", dones);
        end
        obs_rd = obs_q.size();
        run_copy("after_reset", 32'h120, 32'hA00, 16'd2, 2, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_copy("b2b_first", 32'h130, 32'hB00, 16'd2, 2, 1'b0);
        run_copy("b2b_second", 32'h200, 32'hB40, 16'd4, 4, 1'b0);
    endtask

    initial begin
        test_reset();
        test_copy();
        test_zero_len();
        test_retry_ok();
        test_retry_exhaust();
        test_timeout();
        test_err();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
